// File: rtl/mem_access_unit_if.sv
// SRAM request/ack bus between the memory access unit and the data SRAM.
// The unit holds the request stable until a one-cycle ack returns.
interface mem_access_unit_if;
   logic        sram_req;
   logic        sram_we;
   logic [6:0]  sram_addr;
   logic [3:0]  sram_be;
   logic [31:0] sram_wdata;
   logic        sram_ack;
   logic [31:0] sram_rdata;

   modport master (
      output sram_req,
      output sram_we,
      output sram_addr,
      output sram_be,
      output sram_wdata,
      input  sram_ack,
      input  sram_rdata
   );

   modport slave (
      input  sram_req,
      input  sram_we,
      input  sram_addr,
      input  sram_be,
      input  sram_wdata,
      output sram_ack,
      output sram_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns, issues one SRAM access per instruction,
// stalls the pipeline until ack or timeout, and returns the extended load.
module mem_access_unit #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [8:0]        addr,
   input  logic [31:0]       wr_data,
   input  logic [2:0]        func3,
   output logic [31:0]       rd_data,
   output logic              stall,
   output logic              misalign,
   output logic              timeout,
   mem_access_unit_if.master sram
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          access;
   logic          mis;
   logic          accept;
   logic          expire;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic          we_q;
   logic [6:0]    addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic [2:0]    f3_q;
   logic [1:0]    lane_q;
   logic [31:0]   lane;
   logic [31:0]   load_val;

   assign access = mem_read | mem_write;

   always_comb begin
      mis   = 1'b0;
      be    = 4'b1111;
      wdata = wr_data;
      unique case (func3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{wr_data[7:0]}};
         end
         2'b01: begin
            mis   = addr[0];
            be    = 4'b0011 << addr[1:0];
            wdata = {2{wr_data[15:0]}};
         end
         default: mis = |addr[1:0];
      endcase
   end

   // Gated by reset so the combinational outputs also drop asynchronously.
   assign misalign = reset & (state == IDLE) & access & mis;
   assign accept   = reset & (state == IDLE) & access & ~mis;
   assign stall    = accept | (state == REQ);
   assign expire   = (state == REQ) & ~sram.sram_ack & (cnt == CNT_LAST);

   assign sram.sram_req   = (state == REQ);
   assign sram.sram_we    = we_q;
   assign sram.sram_addr  = addr_q;
   assign sram.sram_be    = be_q;
   assign sram.sram_wdata = wdata_q;

   assign lane = sram.sram_rdata >> {lane_q, 3'b000};

   always_comb begin
      load_val = lane;
      unique case (f3_q)
         3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
         3'b100:  load_val = {24'd0, lane[7:0]};
         3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
         3'b101:  load_val = {16'd0, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         lane_q  <= '0;
         rd_data <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state   <= REQ;
                  cnt     <= '0;
                  we_q    <= mem_write;
                  addr_q  <= addr[8:2];
                  be_q    <= be;
                  wdata_q <= wdata;
                  f3_q    <= func3;
                  lane_q  <= addr[1:0];
               end
            end
            REQ: begin
               if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
               if (sram.sram_ack) begin
                  state <= DONE;
                  if (!we_q) rd_data <= load_val;
               end else if (expire) begin
                  state   <= DONE;
                  timeout <= 1'b1;
                  if (!we_q) rd_data <= '0;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level SRAM model, per-cycle compare
// process and directed accesses with hand-computed results.
module tb_mem_access_unit;
   localparam int TO = 16;

   logic        clk;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  func3;
   logic [31:0] rd_data;
   logic        stall;
   logic        misalign;
   logic        timeout;

   mem_access_unit_if bus();

   mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .addr     (addr),
      .wr_data  (wr_data),
      .func3    (func3),
      .rd_data  (rd_data),
      .stall    (stall),
      .misalign (misalign),
      .timeout  (timeout),
      .sram     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic        exp_stall, exp_mis, exp_to, exp_req, exp_we;
   logic [6:0]  exp_addr;
   logic [3:0]  exp_be;
   logic [31:0] exp_wdata, exp_rd;
   logic        chk_en;

   int          n_stall, n_req, n_mis, n_to;
   logic        snap_we;
   logic [6:0]  snap_addr;
   logic [3:0]  snap_be;
   logic [31:0] snap_wdata;

   logic [7:0]  bmem [512];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] f3);
      return f3[1] ? 4 : (f3[0] ? 2 : 1);
   endfunction

   function automatic logic m_mis(input logic [2:0] f3, input logic [8:0] a);
      return (int'(a) % sz(f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [8:0] a);
      logic [3:0] r;
      int o;
      o = int'(a) % 4;
      r = '0;
      for (int b = 0; b < 4; b++) r[b] = (b >= o) && (b < o + sz(f3));
      return r;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % sz(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] word,
                                          input logic [2:0] f3,
                                          input logic [8:0] a);
      logic [63:0] v;
      int n;
      n = sz(f3);
      v = {32'd0, word} >> (8 * (int'(a) % 4));
      v = v & ((64'd1 << (8 * n)) - 64'd1);
      if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1)))
         v = v - (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   function automatic logic [31:0] rd_word(input logic [8:0] a);
      int w;
      w = int'(a) & ~3;
      return {bmem[w+3], bmem[w+2], bmem[w+1], bmem[w]};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'd0, stall}, {31'd0, exp_stall});
         check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
         check("timeout", {31'd0, timeout}, {31'd0, exp_to});
         check("sram_req", {31'd0, bus.sram_req}, {31'd0, exp_req});
         check("rd_data", rd_data, exp_rd);
         if (exp_req) begin
            check("sram_we", {31'd0, bus.sram_we}, {31'd0, exp_we});
            check("sram_addr", {25'd0, bus.sram_addr}, {25'd0, exp_addr});
            check("sram_be", {28'd0, bus.sram_be}, {28'd0, exp_be});
            check("sram_wdata", bus.sram_wdata, exp_wdata);
         end
         n_stall += int'(stall);
         n_mis   += int'(misalign);
         n_to    += int'(timeout);
         if (bus.sram_req) begin
            n_req++;
            snap_we    = bus.sram_we;
            snap_addr  = bus.sram_addr;
            snap_be    = bus.sram_be;
            snap_wdata = bus.sram_wdata;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic r, input logic w, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd,
                         input int lat);
      logic [31:0] word;
      logic [3:0]  mbe;
      logic [31:0] mwd;
      logic        tmo;
      int          wb;
      n_stall = 0;
      n_req   = 0;
      n_mis   = 0;
      n_to    = 0;
      cyc();
      mem_read  = r;
      mem_write = w;
      func3     = f3;
      addr      = a;
      wr_data   = wd;
      exp_mis   = m_mis(f3, a);
      exp_stall = !exp_mis;
      exp_req   = 1'b0;
      exp_to    = 1'b0;
      if (exp_mis) begin
         cyc();
         mem_read  = 1'b0;
         mem_write = 1'b0;
         exp_mis   = 1'b0;
         exp_stall = 1'b0;
         return;
      end
      mbe       = m_be(f3, a);
      mwd       = m_wdata(f3, wd);
      word      = rd_word(a);
      exp_we    = w;
      exp_addr  = a[8:2];
      exp_be    = mbe;
      exp_wdata = mwd;
      for (int n = 0; n < TO; n++) begin
         cyc();
         exp_req = 1'b1;
         if (n == lat) begin
            bus.sram_ack   = 1'b1;
            bus.sram_rdata = word;
            break;
         end
      end
      cyc();
      bus.sram_ack = 1'b0;
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      tmo       = (lat >= TO);
      exp_to    = tmo;
      if (!w) begin
         exp_rd = tmo ? 32'd0 : m_load(word, f3, a);
      end else if (!tmo) begin
         wb = int'(a) & ~3;
         for (int b = 0; b < 4; b++)
            if (mbe[b]) bmem[wb+b] = mwd[8*b +: 8];
      end
      cyc();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      exp_to    = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      addr = '0;
      wr_data = '0;
      func3 = '0;
      bus.sram_ack = 1'b0;
      bus.sram_rdata = '0;
      exp_stall = 0; exp_mis = 0; exp_to = 0; exp_req = 0; exp_we = 0;
      exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_rd = '0;
      n_stall = 0; n_req = 0; n_mis = 0; n_to = 0;
      snap_we = 0; snap_addr = '0; snap_be = '0; snap_wdata = '0;
      for (int i = 0; i < 512; i++) bmem[i] = 8'h00;
      bmem[9'h012] = 8'hFF;
      bmem[9'h013] = 8'h80;
      chk_en = 1'b1;

      cyc();
      check("rst_rd", rd_data, 32'h0);
      check("rst_be", {28'd0, bus.sram_be}, 32'h0);
      check("rst_wdata", bus.sram_wdata, 32'h0);
      cyc();
      reset = 1'b1;

      access(1'b1, 1'b0, 3'b000, 9'h013, 32'h0, 0);
      check("lb_rd", rd_data, 32'hFFFFFF80);
      check("lb_stall_cyc", n_stall, 2);
      check("lb_req_cyc", n_req, 1);
      access(1'b1, 1'b0, 3'b100, 9'h013, 32'h0, 0);
      check("lbu_rd", rd_data, 32'h00000080);

      access(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 0);
      check("sw_addr", {25'd0, snap_addr}, 32'd4);
      check("sw_be", {28'd0, snap_be}, 32'hF);
      check("sw_we", {31'd0, snap_we}, 32'd1);
      check("sw_wdata", snap_wdata, 32'hDEADBEEF);
      check("sw_stall_cyc", n_stall, 2);
      check("sw_rd_kept", rd_data, 32'h00000080);

      access(1'b0, 1'b1, 3'b001, 9'h006, 32'h0000ABCD, 2);
      check("sh_be", {28'd0, snap_be}, 32'hC);
      check("sh_wdata", snap_wdata, 32'hABCDABCD);
      check("sh_req_cyc", n_req, 3);
      check("sh_stall_cyc", n_stall, 4);

      access(1'b1, 1'b0, 3'b001, 9'h012, 32'h0, 1);
      check("lh_rd", rd_data, 32'hFFFFDEAD);
      access(1'b1, 1'b0, 3'b101, 9'h012, 32'h0, 0);
      check("lhu_rd", rd_data, 32'h0000DEAD);
      access(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 0);
      check("lw_rd", rd_data, 32'hDEADBEEF);

      access(1'b1, 1'b1, 3'b000, 9'h005, 32'h12345677, 0);
      check("sb_be", {28'd0, snap_be}, 32'h2);
      check("sb_we", {31'd0, snap_we}, 32'd1);
      check("sb_wdata", snap_wdata, 32'h77777777);
      check("sb_rd_kept", rd_data, 32'hDEADBEEF);
      access(1'b1, 1'b0, 3'b010, 9'h004, 32'h0, 0);
      check("lw4_rd", rd_data, 32'hABCD7700);

      access(1'b1, 1'b0, 3'b010, 9'h002, 32'h0, 0);
      cyc();
      check("mis_cyc", n_mis, 1);
      check("mis_req_cyc", n_req, 0);
      check("mis_stall_cyc", n_stall, 0);
      access(1'b1, 1'b0, 3'b001, 9'h001, 32'h0, 0);
      cyc();
      check("mish_cyc", n_mis, 1);

      bus.sram_ack = 1'b1;
      bus.sram_rdata = 32'h12345678;
      cyc();
      bus.sram_ack = 1'b0;
      cyc();
      check("idle_ack_rd", rd_data, 32'hABCD7700);

      access(1'b1, 1'b0, 3'b010, 9'h020, 32'h0, TO + 4);
      check("to_pulse", n_to, 1);
      check("to_req_cyc", n_req, 16);
      check("to_stall_cyc", n_stall, 17);
      check("to_rd", rd_data, 32'h0);

      cyc();
      mem_read  = 1'b1;
      func3     = 3'b010;
      addr      = 9'h040;
      wr_data   = 32'h5A5A5A5A;
      exp_stall = 1'b1;
      exp_we    = 1'b0;
      exp_addr  = 7'h10;
      exp_be    = m_be(3'b010, 9'h040);
      exp_wdata = m_wdata(3'b010, 32'h5A5A5A5A);
      cyc();
      exp_req = 1'b1;
      cyc();
      cyc();
      #1;
      reset     = 1'b0;
      mem_read  = 1'b0;
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      exp_rd    = '0;
      #1;
      check("arst_req", {31'd0, bus.sram_req}, 32'd0);
      check("arst_stall", {31'd0, stall}, 32'd0);
      check("arst_we", {31'd0, bus.sram_we}, 32'd0);
      check("arst_addr", {25'd0, bus.sram_addr}, 32'd0);
      check("arst_be", {28'd0, bus.sram_be}, 32'd0);
      cyc();
      cyc();
      #2;
      reset = 1'b1;
      cyc();
      access(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 0);
      check("post_rst_lw", rd_data, 32'hDEADBEEF);

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
